fetch_decode_buffer: RTL

- Two-entry pipeline buffer between instruction fetch and decode.
- Carries each fetched instruction and its PC+2 into decode, and presents the instruction's low 11 bits to the immediate-extension unit.
- Provides valid/ready backpressure so a decode stall never drops an instruction.
- Handles branch flush with NOP insertion and sticky halt blocking.

---
 rtl/fetch_decode_buffer_if.sv | 31 +++
 rtl/fetch_decode_buffer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fetch_decode_buffer_if.sv
// Fetch-to-decode handshake bundle.
//   in_*   : fetch side (valid/ready, instruction, PC+2) plus branch flush
//   out_*  : decode side (valid/ready, head instruction, PC+2, imm field, halt)
//   stall_count : saturating count of decode-stall cycles
// Modports: master = fetch/decode environment, slave = the buffer itself.
interface fetch_decode_buffer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_instr;
  logic [WIDTH-1:0] in_pc_inc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc_inc;
  logic [10:0]      out_extend;
  logic             out_halt;
  logic [15:0]      stall_count;

  modport master (
    output in_valid, in_instr, in_pc_inc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc_inc, out_extend, out_halt, stall_count
  );

  modport slave (
    input  in_valid, in_instr, in_pc_inc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc_inc, out_extend, out_halt, stall_count
  );
endinterface

// File: rtl/fetch_decode_buffer.sv
// Two-entry fetch/decode pipeline buffer with backpressure, branch flush and
// sticky halt blocking.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fetch_decode_buffer_if.slave (handshake, data, flush, status)
module fetch_decode_buffer #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]       HALT_OP   = 5'b00000
) (
  input logic                  clk,
  input logic                  rst,
  fetch_decode_buffer_if.slave bus
);

  logic [WIDTH-1:0] head_instr_q, head_instr_d;
  logic [WIDTH-1:0] head_pc_q, head_pc_d;
  logic [WIDTH-1:0] tail_instr_q, tail_instr_d;
  logic [WIDTH-1:0] tail_pc_q, tail_pc_d;
  logic [1:0]       count_q, count_d;
  logic             halt_seen_q, halt_seen_d;
  logic [15:0]      stall_q, stall_d;

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  // in_ready comes from registered state only, so fetch never sees a
  // combinational path from decode's out_ready.
  assign in_ready  = (count_q < 2'd2) && !halt_seen_q;
  assign out_valid = (count_q != 2'd0);
  assign push      = bus.in_valid && in_ready && !bus.flush;
  assign pop       = out_valid && bus.out_ready;

  always_comb begin
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    count_d      = count_q;
    halt_seen_d  = halt_seen_q;

    if (bus.flush) begin
      count_d     = 2'd0;
      halt_seen_d = 1'b0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_instr_d = bus.in_instr;
            head_pc_d    = bus.in_pc_inc;
            count_d      = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_instr_d = bus.in_instr;
            head_pc_d    = bus.in_pc_inc;
          end else if (push) begin
            tail_instr_d = bus.in_instr;
            tail_pc_d    = bus.in_pc_inc;
            count_d      = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
            count_d      = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase

      if (push && (bus.in_instr[WIDTH-1 -: 5] == HALT_OP)) begin
        halt_seen_d = 1'b1;
      end
    end

    // Stall counting is independent of flush and saturates.
    stall_d = stall_q;
    if (out_valid && !bus.out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_instr_q <= '0;
      head_pc_q    <= '0;
      tail_instr_q <= '0;
      tail_pc_q    <= '0;
      count_q      <= 2'd0;
      halt_seen_q  <= 1'b0;
      stall_q      <= 16'd0;
    end else begin
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
      count_q      <= count_d;
      halt_seen_q  <= halt_seen_d;
      stall_q      <= stall_d;
    end
  end

  logic [WIDTH-1:0] out_instr;
  assign out_instr = out_valid ? head_instr_q : NOP_INSTR;

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_instr   = out_instr;
  assign bus.out_pc_inc  = out_valid ? head_pc_q : '0;
  assign bus.out_extend  = out_instr[10:0];
  assign bus.out_halt    = out_valid && (out_instr[WIDTH-1 -: 5] == HALT_OP);
  assign bus.stall_count = stall_q;

endmodule
